// File: rtl/fwd_hazard_unit.sv
// Forwarding-select, load-use stall and branch-flush control for the 5-stage RV32 pipeline.
// Shadows destination-register info through ID/EX, EX/MEM and MEM/WB.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    // Payload fields travel separately from the valid bits so only the valids need reset.
    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } id_ex_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } wr_info_t;

    id_ex_t     id_ex_q,  id_ex_d;
    wr_info_t   ex_mem_q, ex_mem_d;
    wr_info_t   mem_wb_q, mem_wb_d;

    logic       id_ex_valid_q,  id_ex_valid_d;
    logic       ex_mem_valid_q, ex_mem_valid_d;
    logic       mem_wb_valid_q, mem_wb_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       load_use_raw;

    // A stage "writes r" only when it is a live register-writing instruction to a non-x0 target.
    function automatic logic stage_writes(input logic              valid,
                                          input logic              regwrite,
                                          input logic [REG_AW-1:0] rd,
                                          input logic [REG_AW-1:0] r);
        return valid && regwrite && (rd == r) && (r != '0);
    endfunction

    function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = SEL_RF;
        if (id_ex_valid_q) begin
            if (stage_writes(ex_mem_valid_q, ex_mem_q.regwrite, ex_mem_q.rd, rs)) begin
                sel = SEL_ALU;
            end else if (stage_writes(mem_wb_valid_q, mem_wb_q.regwrite, mem_wb_q.rd, rs)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        fwd_a_sel    = SEL_RF;
        fwd_b_sel    = SEL_RF;
        load_use_raw = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;

        fwd_a_sel = fwd_select(id_ex_q.rs1);
        fwd_b_sel = fwd_select(id_ex_q.rs2);

        load_use_raw = id_valid && id_ex_valid_q && id_ex_q.memread && id_ex_q.regwrite
                       && (id_ex_q.rd != '0)
                       && ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2));

        // A taken branch squashes the dependent ID instruction, so it overrides the stall.
        flush = ex_branch_taken;
        stall = load_use_raw && !ex_branch_taken;
    end

    always_comb begin
        id_ex_d  = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                     regwrite: id_regwrite, memread: id_memread};
        ex_mem_d = '{rd: id_ex_q.rd, regwrite: id_ex_q.regwrite, memread: id_ex_q.memread};
        mem_wb_d = ex_mem_q;

        id_ex_valid_d  = id_valid && !stall && !flush;
        ex_mem_valid_d = id_ex_valid_q;
        mem_wb_valid_d = ex_mem_valid_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: only the valid bits and the counter are reset; payload is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignment so all stages shift simultaneously.
            id_ex_valid_q  <= 1'b0;
            ex_mem_valid_q <= 1'b0;
            mem_wb_valid_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            id_ex_valid_q  <= id_ex_valid_d;
            ex_mem_valid_q <= ex_mem_valid_d;
            mem_wb_valid_q <= mem_wb_valid_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        id_ex_q  <= id_ex_d;
        ex_mem_q <= ex_mem_d;
        mem_wb_q <= mem_wb_d;
    end

    assign stall_cnt = stall_cnt_q;

    // Load flags past EX are kept for debug visibility; forwarding never needs them.
    logic unused_memread;
    assign unused_memread = ex_mem_q.memread ^ mem_wb_q.memread;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes expected outputs into a queue,
// a monitor pops and compares mid-cycle. A second instance with CNT_W=2 checks saturation.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_memread, ex_branch_taken;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, flush;
    logic [15:0] stall_cnt;

    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic        s_stall, s_flush;
    logic [1:0]  s_stall_cnt;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       fl;
        int         cnt;
        int         cnt2;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fwd_hazard_unit u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall(s_stall), .flush(s_flush), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        checks++;
        if (fwd_a_sel !== e.a || fwd_b_sel !== e.b || stall !== e.st || flush !== e.fl ||
            int'(stall_cnt) != e.cnt || s_fwd_a_sel !== e.a || s_fwd_b_sel !== e.b ||
            s_stall !== e.st || s_flush !== e.fl || int'(s_stall_cnt) != e.cnt2) begin
            failures++;
            $display("FAIL %s: got a=%0d b=%0d stall=%0d flush=%0d cnt=%0d sat(a=%0d b=%0d stall=%0d flush=%0d cnt=%0d) expected a=%0d b=%0d stall=%0d flush=%0d cnt=%0d cnt2=%0d",
                     e.name, fwd_a_sel, fwd_b_sel, stall, flush, stall_cnt,
                     s_fwd_a_sel, s_fwd_b_sel, s_stall, s_flush, s_stall_cnt,
                     e.a, e.b, e.st, e.fl, e.cnt, e.cnt2);
        end
    endtask

    // Monitor: outputs are combinational every cycle, so each cycle presents one response.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check(exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs (called just after a rising edge) and queue its expected outputs.
    task automatic cyc(input bit r, input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr, input bit br,
                       input logic [1:0] ea, input logic [1:0] eb, input bit est, input bit efl,
                       input int ecnt, input int ecnt2, input string nm);
        exp_t e;
        rst             = r;
        id_valid        = v;
        id_rs1          = 5'(rs1);
        id_rs2          = 5'(rs2);
        id_rd           = 5'(rd);
        id_regwrite     = rw;
        id_memread      = mr;
        ex_branch_taken = br;
        e.a = ea; e.b = eb; e.st = est; e.fl = efl;
        e.cnt = ecnt; e.cnt2 = ecnt2; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; ex_branch_taken = 1'b0;
        @(posedge clk);
        #1;

        //  rst v rs1 rs2 rd rw mr br | a  b  st fl cnt cnt2
        cyc(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, "reset_idle");
        cyc(0, 1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, "issue_add_x5");
        cyc(0, 1, 5, 5, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0, "issue_sub");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   2, 2, 0, 0, 0, 0, "exmem_fwd_ab");
        cyc(0, 1, 3, 4, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, "issue_add_x5_b");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, "nop_gap");
        cyc(0, 1, 8, 5, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0, "issue_or_rs2_5");
        cyc(0, 1, 3, 4, 5, 1, 0, 0,   0, 1, 0, 0, 0, 0, "memwb_fwd_b");
        cyc(0, 1, 3, 4, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, "issue_add_x5_d");
        cyc(0, 1, 5, 9, 10, 1, 0, 0,  0, 0, 0, 0, 0, 0, "issue_or_rs1_5");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, "priority_exmem");
        // Load-use: one stall cycle, then forwarding from MEM/WB.
        cyc(0, 1, 2, 0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0, "issue_lw_x7");
        cyc(0, 1, 7, 1, 11, 1, 0, 0,  0, 0, 1, 0, 0, 0, "load_use_stall");
        cyc(0, 1, 7, 1, 11, 1, 0, 0,  0, 0, 0, 0, 1, 1, "stall_one_cycle");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, "load_fwd_memwb");
        // x0 is never forwarded or stalled on.
        cyc(0, 1, 1, 2, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, "issue_lw_x0");
        cyc(0, 1, 0, 0, 12, 1, 0, 0,  0, 0, 0, 0, 1, 1, "x0_no_stall");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, "x0_no_fwd");
        // Flush overrides a load-use stall.
        cyc(0, 1, 2, 0, 7, 1, 1, 0,   0, 0, 0, 0, 1, 1, "issue_lw_x7_b");
        cyc(0, 1, 7, 1, 11, 1, 0, 1,  0, 0, 0, 1, 1, 1, "flush_beats_stall");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, "flush_bubble");
        // Chain of dependent loads: stall every other cycle, saturating the 2-bit counter.
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   0, 0, 0, 0, 1, 1, "sat_prime");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   0, 0, 1, 0, 1, 1, "sat_stall1");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   0, 0, 0, 0, 2, 2, "sat_bubble1");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   1, 0, 1, 0, 2, 2, "sat_stall2");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   0, 0, 0, 0, 3, 3, "sat_bubble2");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   1, 0, 1, 0, 3, 3, "sat_stall3");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   0, 0, 0, 0, 4, 3, "sat_bubble3");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   1, 0, 1, 0, 4, 3, "sat_stall4");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   0, 0, 0, 0, 5, 3, "sat_bubble4");
        cyc(0, 1, 7, 0, 7, 1, 1, 0,   1, 0, 1, 0, 5, 3, "sat_stall5");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 6, 3, "sat_hold");
        // Mid-run reset while EX/MEM holds a matching writer.
        cyc(0, 1, 1, 2, 5, 1, 0, 0,   0, 0, 0, 0, 6, 3, "issue_add_x5_r");
        cyc(0, 1, 5, 5, 6, 1, 0, 0,   0, 0, 0, 0, 6, 3, "issue_sub_r");
        cyc(1, 0, 0, 0, 0, 0, 0, 0,   2, 2, 0, 0, 6, 3, "pre_reset_fwd");
        cyc(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, "post_reset_clear");
        cyc(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, "idle_end");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
